// File: rtl/lab1_chk_pkg.sv
// lab1_chk_pkg: shared FSM encoding and widths for the lab1 response checker
package lab1_chk_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int ERR_W = 5;
  localparam int CNT_W = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = 5'd31;
endpackage

// File: rtl/lab1_sat_cnt.sv
// lab1_sat_cnt: W-bit saturating counter (clk, rst async, clr, inc -> cnt stops at MAX, clr wins)
module lab1_sat_cnt #(
  parameter int W = 5,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= clr ? '0 : (inc && cnt != MAX) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/lab1_resp_checker.sv
// lab1_resp_checker: checks strobed abcd/f/g against EXP_F/EXP_G over NUM_VEC samples (in: clk rst start in_valid abcd f g; out: busy done pass err_count first_err_vec first_err_valid, cov_mask with LAB1_CHK_COVERAGE_EN)
module lab1_resp_checker
  import lab1_chk_pkg::*;
#(
  parameter logic [15:0] EXP_F = 16'h6996,
  parameter logic [15:0] EXP_G = 16'h8000,
  parameter int NUM_VEC = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [3:0]       abcd,
  input  logic             f,
  input  logic             g,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       first_err_vec,
  output logic             first_err_valid
`ifdef LAB1_CHK_COVERAGE_EN
  ,
  output logic [15:0]      cov_mask
`endif
);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic samp, err_inc, last, cov_ok;
  always_comb begin
    samp = state == RUN && in_valid && !start;
    err_inc = samp && (f != EXP_F[abcd] || g != EXP_G[abcd]);
    last = samp && cnt == CNT_W'(NUM_VEC - 1);
    state_n = start ? RUN : last ? DONE : state;
  end
`ifdef LAB1_CHK_COVERAGE_EN
  logic [15:0] cov_n;
  always_comb cov_n = start ? 16'h0 : samp ? cov_mask | (16'h1 << abcd) : cov_mask;
  assign cov_ok = &cov_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) cov_mask <= '0;
    else cov_mask <= cov_n;
`else
  assign cov_ok = 1'b1;
`endif
  lab1_sat_cnt #(.W(ERR_W), .MAX(ERR_MAX)) u_err (
    .clk(clk),
    .rst(rst),
    .clr(start),
    .inc(err_inc),
    .cnt(err_count)
  );
  // pass is computed from next-state values so it is valid together with done
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      first_err_vec <= '0;
      first_err_valid <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= start ? '0 : samp ? cnt + 1'b1 : cnt;
      busy <= state_n == RUN;
      done <= state_n == DONE;
      pass <= state_n == DONE && err_count == '0 && !err_inc && cov_ok;
      if (start) begin
        first_err_vec <= '0;
        first_err_valid <= 1'b0;
      end else if (err_inc && !first_err_valid) begin
        first_err_vec <= abcd;
        first_err_valid <= 1'b1;
      end
    end
endmodule
